// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: datapath widths, ALU opcodes, forward selects.
package riscv_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_REGW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational RV32I ALU with zero flag for branch resolution.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    logic w_lt;

    assign w_lt = $signed(SrcA) < $signed(SrcB);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_XOR: Result = SrcA ^ SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, w_lt};
            ALU_SLL: Result = SrcA << SrcB[4:0];
            ALU_SRL: Result = SrcA >> SrcB[4:0];
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, beq/bne resolution and the EX/MEM register.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int REGW = DEF_REGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic            BranchNeE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [REGW-1:0] RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic            FlushE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [REGW-1:0] RD_M,
    output logic [XLEN-1:0] ALU_ResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] w_src_a, w_fwd_b, w_src_b, w_alu_result;
    logic            w_zero;

    logic            r_reg_write, r_mem_write, r_result_src;
    logic [REGW-1:0] r_rd;
    logic [XLEN-1:0] r_alu_result, r_write_data, r_pc_plus4;

    // MEM forward uses the registered result, so a back-to-back dependence sees edge n's value.
    always_comb begin
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = r_alu_result;
            default: w_src_a = RD1_E;
        endcase
        case (ForwardBE)
            FWD_WB:  w_fwd_b = ResultW;
            FWD_MEM: w_fwd_b = r_alu_result;
            default: w_fwd_b = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (w_src_a),
        .SrcB       (w_src_b),
        .ALUControl (ALUControlE),
        .Result     (w_alu_result),
        .Zero       (w_zero)
    );

    assign PCSrcE    = BranchE & (w_zero ^ BranchNeE);
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 1'b0;
            r_rd         <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
        end else begin
            // A flushed slot only needs its side-effect controls killed; data is don't-care.
            r_reg_write  <= RegWriteE & ~FlushE;
            r_mem_write  <= MemWriteE & ~FlushE;
            r_rd         <= FlushE ? '0 : RD_E;
            r_result_src <= ResultSrcE;
            r_alu_result <= w_alu_result;
            r_write_data <= w_fwd_b;
            r_pc_plus4   <= PCPlus4E;
        end
    end

    assign RegWriteM   = r_reg_write;
    assign MemWriteM   = r_mem_write;
    assign ResultSrcM  = r_result_src;
    assign RD_M        = r_rd;
    assign ALU_ResultM = r_alu_result;
    assign WriteDataM  = r_write_data;
    assign PCPlus4M    = r_pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed literal checks plus random traffic against a behavioural model.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, BranchNeE, ALUSrcE, FlushE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE, RegWriteM, MemWriteM, ResultSrcM;
    logic [31:0] PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RD_M;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .BranchNeE(BranchNeE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model of what the EX/MEM register must hold; e_dv=0 after a flush (data don't-care).
    logic [31:0] e_alu = '0, e_wd = '0, e_pc4 = '0;
    logic        e_rw = 1'b0, e_mw = 1'b0, e_rs = 1'b0;
    logic [4:0]  e_rd = '0;
    bit          e_dv = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint unsigned ua, ub, p2;
        ua = a;
        ub = b;
        p2 = 64'd1 << b[4:0];
        case (op)
            3'd0: return 32'(ua + ub);
            3'd1: return 32'(ua + 64'h1_0000_0000 - ub);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd6: return 32'(ua * p2);
            default: return 32'(ua / p2);
        endcase
    endfunction

    task automatic clr();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; BranchNeE = 0;
        ALUSrcE = 0; FlushE = 0; ALUControlE = 3'd0; RD1_E = 0; RD2_E = 0;
        Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0; RD_E = 0;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
    endtask

    // One cycle: check combinational outputs on the applied inputs, clock, check registers.
    task automatic step();
        logic [31:0] fa, fb, sb, r;
        logic        taken;
        #1;
        fa = (ForwardAE == 2'b01) ? ResultW : (ForwardAE == 2'b10) ? e_alu : RD1_E;
        fb = (ForwardBE == 2'b01) ? ResultW : (ForwardBE == 2'b10) ? e_alu : RD2_E;
        sb = ALUSrcE ? Imm_Ext_E : fb;
        r  = m_alu(ALUControlE, fa, sb);
        taken = BranchE && ((r == 32'd0) != BranchNeE);
        chk("PCSrcE", {31'b0, PCSrcE}, {31'b0, taken});
        chk("PCTargetE", PCTargetE, PCE + Imm_Ext_E);
        @(posedge clk);
        #1;
        if (rst) begin
            e_rw = 0; e_mw = 0; e_rs = 0; e_rd = 0; e_alu = 0; e_wd = 0; e_pc4 = 0; e_dv = 1;
        end else begin
            e_rw  = FlushE ? 1'b0 : RegWriteE;
            e_mw  = FlushE ? 1'b0 : MemWriteE;
            e_rd  = FlushE ? 5'd0 : RD_E;
            e_rs  = ResultSrcE;
            e_alu = r;
            e_wd  = fb;
            e_pc4 = PCPlus4E;
            e_dv  = !FlushE;
        end
        chk("RegWriteM", {31'b0, RegWriteM}, {31'b0, e_rw});
        chk("MemWriteM", {31'b0, MemWriteM}, {31'b0, e_mw});
        chk("RD_M", {27'b0, RD_M}, {27'b0, e_rd});
        if (e_dv) begin
            chk("ResultSrcM", {31'b0, ResultSrcM}, {31'b0, e_rs});
            chk("ALU_ResultM", ALU_ResultM, e_alu);
            chk("WriteDataM", WriteDataM, e_wd);
            chk("PCPlus4M", PCPlus4M, e_pc4);
        end
    endtask

    initial begin
        clr();
        // Reset held for two edges with live inputs
        rst = 1; RegWriteE = 1; RD_E = 5'd5; RD1_E = 32'd7;
        step(); step();
        chk("rst RD_M", {27'b0, RD_M}, 32'd0);
        chk("rst ALU_ResultM", ALU_ResultM, 32'd0);
        chk("rst RegWriteM", {31'b0, RegWriteM}, 32'd0);
        rst = 0;
        step();
        chk("post-rst RD_M", {27'b0, RD_M}, 32'd5);
        chk("post-rst RegWriteM", {31'b0, RegWriteM}, 32'd1);
        chk("post-rst ALU", ALU_ResultM, 32'd7);

        // MEM forward back-to-back
        clr(); RD1_E = 3; RD2_E = 4; step();
        chk("add 3+4", ALU_ResultM, 32'd7);
        ForwardAE = 2'b10; RD1_E = 100; RD2_E = 1; step();
        chk("mem fwd", ALU_ResultM, 32'd8);

        // WB forward on B into a store
        clr(); ForwardBE = 2'b01; ResultW = 32'hDEAD_BEEF; ALUSrcE = 1; Imm_Ext_E = 32'd8;
        RD1_E = 32'h1000; MemWriteE = 1; step();
        chk("store addr", ALU_ResultM, 32'h1008);
        chk("store data", WriteDataM, 32'hDEAD_BEEF);
        chk("store MemWriteM", {31'b0, MemWriteM}, 32'd1);

        // Branches
        clr(); PCE = 32'h40; Imm_Ext_E = -32'sd16; BranchE = 1; ALUControlE = 3'd1;
        RD1_E = 5; RD2_E = 5; #1;
        chk("beq taken", {31'b0, PCSrcE}, 32'd1);
        chk("br target", PCTargetE, 32'h30);
        step();
        BranchNeE = 1; #1;
        chk("bne eq", {31'b0, PCSrcE}, 32'd0);
        step();
        RD2_E = 6; #1;
        chk("bne ne", {31'b0, PCSrcE}, 32'd1);
        step();

        // Signed slt
        clr(); ALUControlE = 3'd5; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; step();
        chk("slt -1<1", ALU_ResultM, 32'd1);
        RD1_E = 32'd1; RD2_E = 32'hFFFF_FFFF; step();
        chk("slt 1<-1", ALU_ResultM, 32'd0);

        // Flush, then flush under reset
        clr(); RegWriteE = 1; MemWriteE = 1; RD_E = 5'd9; FlushE = 1; step();
        chk("flush RegWriteM", {31'b0, RegWriteM}, 32'd0);
        chk("flush MemWriteM", {31'b0, MemWriteM}, 32'd0);
        chk("flush RD_M", {27'b0, RD_M}, 32'd0);
        rst = 1; RD1_E = 32'd55; PCPlus4E = 32'h44; step();
        chk("rst+flush ALU", ALU_ResultM, 32'd0);
        chk("rst+flush PCPlus4M", PCPlus4M, 32'd0);
        rst = 0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            FlushE = ($urandom_range(0, 9) == 0);
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom);
            BranchE = 1'($urandom); BranchNeE = 1'($urandom); ALUSrcE = 1'($urandom);
            ALUControlE = 3'($urandom);
            RD1_E = $urandom; RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
            Imm_Ext_E = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            RD_E = 5'($urandom); PCE = $urandom; PCPlus4E = PCE + 4; ResultW = $urandom;
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            if (!e_dv && ForwardAE == 2'b10) ForwardAE = 2'b00;
            if (!e_dv && ForwardBE == 2'b10) ForwardBE = 2'b00;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
